// File: rtl/ntt_bf_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_bf_addr_gen
//  Purpose  : Butterfly sweep controller for an in-place Cooley-Tukey forward
//             NTT. Issues u/v read addresses and twiddle ROM addresses for
//             every butterfly, and delays them to produce write-back strobes
//             and addresses aligned with the PE output.
//  Revision : 1.0 - initial release
// ============================================================================
module ntt_bf_addr_gen #(
  parameter int LOGN    = 8,
  parameter int MEM_LAT = 1,
  parameter int PE_LAT  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(LOGN):0]     stage,
  output logic                      rd_en,
  output logic [LOGN-1:0]           rd_addr_u,
  output logic [LOGN-1:0]           rd_addr_v,
  output logic [LOGN-1:0]           tw_addr,
  output logic                      wr_en,
  output logic [LOGN-1:0]           wr_addr_u,
  output logic [LOGN-1:0]           wr_addr_v
);

  localparam int HALF = (1 << LOGN) / 2;
  localparam int D    = MEM_LAT + PE_LAT;
  localparam int SW   = $clog2(LOGN) + 1;
  localparam int FW   = $clog2(D + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [LOGN-1:0]        b_q, b_d;
  logic [SW-1:0]          stage_q, stage_d;
  logic [FW-1:0]          flush_q, flush_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   rd_en_q, rd_en_d;
  logic [LOGN-1:0]        rd_addr_u_q, rd_addr_u_d;
  logic [LOGN-1:0]        rd_addr_v_q, rd_addr_v_d;
  logic [LOGN-1:0]        tw_addr_q, tw_addr_d;
  logic [D-1:0]           pipe_vld_q, pipe_vld_d;
  logic [D-1:0][LOGN-1:0] pipe_u_q, pipe_u_d;
  logic [D-1:0][LOGN-1:0] pipe_v_q, pipe_v_d;

  logic [SW-1:0]          sh_w;
  logic [LOGN-1:0]        len_w, g_w, k_w, u_w, v_w, tw_w;

  // Sequencing: next state, butterfly/stage/flush counters and read strobe
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    stage_d = stage_q;
    flush_d = flush_q;
    rd_en_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE also accepts start so back-to-back transforms lose no cycle
        if (start) begin
          state_d = ST_ISSUE;
          b_d     = '0;
          stage_d = '0;
          flush_d = '0;
          rd_en_d = 1'b1;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (b_q == LOGN'(HALF - 1)) begin
          state_d = ST_FLUSH;
          flush_d = '0;
        end else begin
          b_d     = b_q + LOGN'(1);
          rd_en_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flush_q == FW'(D - 1)) begin
          if (stage_q == SW'(LOGN - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            stage_d = stage_q + SW'(1);
            b_d     = '0;
            rd_en_d = 1'b1;
          end
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_ISSUE) || (state_d == ST_FLUSH);
    done_d = (state_d == ST_DONE);
  end

  // Butterfly address mapping for the butterfly about to be presented
  always_comb begin
    sh_w  = SW'(LOGN - 1) - stage_d;
    len_w = LOGN'(1) << sh_w;
    g_w   = b_d >> sh_w;
    k_w   = b_d & (len_w - LOGN'(1));
    u_w   = (g_w << (sh_w + SW'(1))) | k_w;
    v_w   = u_w + len_w;
    tw_w  = (LOGN'(1) << stage_d) + g_w;
    rd_addr_u_d = rd_en_d ? u_w  : '0;
    rd_addr_v_d = rd_en_d ? v_w  : '0;
    tw_addr_d   = rd_en_d ? tw_w : '0;
  end

  // Write-back delay line: read strobe and addresses shifted by D cycles
  always_comb begin
    pipe_vld_d[0] = rd_en_q;
    pipe_u_d[0]   = rd_addr_u_q;
    pipe_v_d[0]   = rd_addr_v_q;
    for (int i = 1; i < D; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_u_d[i]   = pipe_u_q[i-1];
      pipe_v_d[i]   = pipe_v_q[i-1];
    end
  end

  // State, counter, output and delay-line registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      b_q         <= '0;
      stage_q     <= '0;
      flush_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_u_q <= '0;
      rd_addr_v_q <= '0;
      tw_addr_q   <= '0;
      pipe_vld_q  <= '0;
      pipe_u_q    <= '0;
      pipe_v_q    <= '0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      stage_q     <= stage_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_u_q <= rd_addr_u_d;
      rd_addr_v_q <= rd_addr_v_d;
      tw_addr_q   <= tw_addr_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_u_q    <= pipe_u_d;
      pipe_v_q    <= pipe_v_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = stage_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_u = rd_addr_u_q;
  assign rd_addr_v = rd_addr_v_q;
  assign tw_addr   = tw_addr_q;
  assign wr_en     = pipe_vld_q[D-1];
  assign wr_addr_u = pipe_u_q[D-1];
  assign wr_addr_v = pipe_v_q[D-1];

endmodule
`default_nettype wire

// File: tb/tb_ntt_bf_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ntt_bf_addr_gen
//  Purpose  : Self-checking bench for ntt_bf_addr_gen (default parameters).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_bf_addr_gen;

  localparam int LOGN  = 8;
  localparam int N     = 1 << LOGN;
  localparam int HALF  = N / 2;
  localparam int D     = 7;
  localparam int FINAL = LOGN * (HALF + D);   // cycle of the last write
  localparam int LAST  = FINAL + 12;
  localparam int NOBS  = 1200;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            busy, done, rd_en, wr_en;
  logic [3:0]      stage;
  logic [LOGN-1:0] rd_addr_u, rd_addr_v, tw_addr, wr_addr_u, wr_addr_v;

  ntt_bf_addr_gen #(.LOGN(LOGN), .MEM_LAT(1), .PE_LAT(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .rd_en     (rd_en),
    .rd_addr_u (rd_addr_u),
    .rd_addr_v (rd_addr_v),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_addr_u (wr_addr_u),
    .wr_addr_v (wr_addr_v)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int u; int v; int tw; int s;} rd_t;
  typedef struct {int cyc; int u; int v;} wr_t;
  // -1 in any field means "not checked"
  typedef struct {int cyc; int rd; int u; int v; int tw; int s; int wr; int dn;} vec_t;

  rd_t  exp_q[$];
  wr_t  wr_q[$];
  vec_t tbl[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cur_cyc  = 0;
  int n_wr;
  int wr_cnt [N];
  int obs_rd [NOBS], obs_u [NOBS], obs_v [NOBS], obs_tw [NOBS];
  int obs_s  [NOBS], obs_wr[NOBS], obs_dn[NOBS];

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cur_cyc, act, exp);
    end
  endfunction

  task automatic chk_all_zero(string tag);
    chk({tag, "_busy"},  int'(busy),  0);
    chk({tag, "_done"},  int'(done),  0);
    chk({tag, "_stage"}, int'(stage), 0);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_addrs"}, int'(rd_addr_u | rd_addr_v | tw_addr | wr_addr_u | wr_addr_v), 0);
  endtask

  // Per-cycle sampling, scoreboard and recording (called at negedge)
  task automatic sample(input int c);
    bit rd_due, wr_due;
    rd_t e;
    wr_t w;
    cur_cyc = c;
    if (c < NOBS) begin
      obs_rd[c] = int'(rd_en);  obs_u[c] = int'(rd_addr_u); obs_v[c] = int'(rd_addr_v);
      obs_tw[c] = int'(tw_addr); obs_s[c] = int'(stage);   obs_wr[c] = int'(wr_en);
      obs_dn[c] = int'(done);
    end
    chk("busy", int'(busy), (c >= 1 && c <= FINAL) ? 1 : 0);
    chk("done", int'(done), (c == FINAL + 1) ? 1 : 0);
    rd_due = (exp_q.size() > 0) && (exp_q[0].cyc == c);
    chk("rd_en", int'(rd_en), int'(rd_due));
    if (rd_en && rd_due) begin
      e = exp_q.pop_front();
      chk("rd_addr_u", int'(rd_addr_u), e.u);
      chk("rd_addr_v", int'(rd_addr_v), e.v);
      chk("tw_addr",   int'(tw_addr),   e.tw);
      chk("stage",     int'(stage),     e.s);
      wr_q.push_back('{c + D, e.u, e.v});
    end
    wr_due = (wr_q.size() > 0) && (wr_q[0].cyc == c);
    chk("wr_en", int'(wr_en), int'(wr_due));
    if (wr_en && wr_due) begin
      w = wr_q.pop_front();
      chk("wr_addr_u", int'(wr_addr_u), w.u);
      chk("wr_addr_v", int'(wr_addr_v), w.v);
      wr_cnt[w.u]++;
      wr_cnt[w.v]++;
      n_wr++;
    end
  endtask

  // One full transform; p1/p2 are cycles carrying a stray start pulse,
  // stop_at != 0 abandons the run after sampling that cycle
  task automatic run_ntt(input int p1, input int p2, input int stop_at);
    int len, bad;
    exp_q.delete();
    wr_q.delete();
    n_wr = 0;
    for (int a = 0; a < N; a++) wr_cnt[a] = 0;
    for (int i = 0; i < NOBS; i++) begin
      obs_rd[i] = -9; obs_u[i] = -9; obs_v[i] = -9; obs_tw[i] = -9;
      obs_s[i]  = -9; obs_wr[i] = -9; obs_dn[i] = -9;
    end
    // Reference schedule: textbook CT loop nest (stage, group, offset)
    for (int s = 0; s < LOGN; s++) begin
      len = N >> (s + 1);
      for (int g = 0; g < (1 << s); g++)
        for (int k = 0; k < len; k++)
          exp_q.push_back('{1 + s * (HALF + D) + g * len + k,
                             g * 2 * len + k, g * 2 * len + k + len, (1 << s) + g, s});
    end
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= LAST; c++) begin
      @(negedge clk);
      start = (c == p1 || c == p2);
      sample(c);
      if (stop_at != 0 && c == stop_at) return;
    end
    start = 1'b0;
    cur_cyc = LAST;
    chk("reads_left", exp_q.size(), 0);
    chk("writes_left", wr_q.size(), 0);
    chk("write_total", n_wr * 2, N * LOGN);
    bad = 0;
    for (int a = 0; a < N; a++) if (wr_cnt[a] != LOGN) bad++;
    chk("addr_write_count_bad", bad, 0);
  endtask

  task automatic check_table();
    vec_t t;
    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      cur_cyc = t.cyc;
      if (t.rd >= 0) chk("tbl_rd_en", obs_rd[t.cyc], t.rd);
      if (t.u  >= 0) chk("tbl_u",     obs_u[t.cyc],  t.u);
      if (t.v  >= 0) chk("tbl_v",     obs_v[t.cyc],  t.v);
      if (t.tw >= 0) chk("tbl_tw",    obs_tw[t.cyc], t.tw);
      if (t.s  >= 0) chk("tbl_stage", obs_s[t.cyc],  t.s);
      if (t.wr >= 0) chk("tbl_wr_en", obs_wr[t.cyc], t.wr);
      if (t.dn >= 0) chk("tbl_done",  obs_dn[t.cyc], t.dn);
    end
  endtask

  initial begin
    //                cyc   rd   u    v    tw   s   wr  dn
    tbl.push_back('{   1,   1,   0, 128,   1,  0,  0,  0});
    tbl.push_back('{   2,   1,   1, 129,   1,  0,  0,  0});
    tbl.push_back('{   8,   1,   7, 135,   1,  0,  1,  0});
    tbl.push_back('{ 128,   1, 127, 255,   1,  0, -1,  0});
    tbl.push_back('{ 129,   0,  -1,  -1,  -1,  0, -1,  0});
    tbl.push_back('{ 132,   0,  -1,  -1,  -1,  0, -1,  0});
    tbl.push_back('{ 135,   0,  -1,  -1,  -1,  0,  1,  0});
    tbl.push_back('{ 136,   1,   0,  64,   2,  1,  0,  0});
    tbl.push_back('{ 200,   1, 128, 192,   3,  1, -1,  0});
    tbl.push_back('{ 946,   1,   0,   1, 128,  7, -1,  0});
    tbl.push_back('{1073,   1, 254, 255, 255,  7, -1,  0});
    tbl.push_back('{1080,   0,  -1,  -1,  -1, -1,  1,  0});
    tbl.push_back('{1081,   0,  -1,  -1,  -1, -1,  0,  1});
    tbl.push_back('{1082,   0,  -1,  -1,  -1, -1,  0,  0});

    // Reset state, both during and after reset
    repeat (2) @(negedge clk);
    cur_cyc = 0;
    chk_all_zero("in_reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("idle");

    // Undisturbed run
    run_ntt(0, 0, 0);
    check_table();

    // Stray start pulses while busy must not perturb anything
    repeat (3) @(negedge clk);
    run_ntt(5, 500, 0);
    check_table();

    // Asynchronous reset in the middle of stage 2
    repeat (3) @(negedge clk);
    run_ntt(0, 0, 300);
    #1 rst = 1'b1;
    #1;
    cur_cyc = 300;
    chk_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      cur_cyc = 300 + i;
      chk("post_rst_wr_en", int'(wr_en), 0);
      chk("post_rst_rd_en", int'(rd_en), 0);
      chk("post_rst_busy",  int'(busy),  0);
    end
    run_ntt(0, 0, 0);
    check_table();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
